iter_divider: RTL and testbench

- Multi-cycle RV32M divide/remainder unit, placed beside the single-cycle ALU in the datapath.
- Implements DIV, DIVU, REM and REMU using a radix-2 restoring algorithm over unsigned magnitudes, with sign correction at the end.
- The control unit launches an operation with a Start/Busy/Done handshake and stalls the PC while Busy is high.

---
 rtl/iter_divider.sv | 163 ++++++++++++++++
 tb/tb_iter_divider.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// Multi-cycle RV32M divide/remainder unit (DIV, DIVU, REM, REMU), radix-2 restoring.
// Optional ALU-style Zero/Negative result flags when DIV_FLAGS_EN is defined.
module iter_divider #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             Start,
    input  logic [1:0]       DivOp,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             DivByZero
`ifdef DIV_FLAGS_EN
    ,
    output logic             Zero,
    output logic             Negative
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               dbz_q, dbz_d;
`ifdef DIV_FLAGS_EN
    logic               zero_q, zero_d;
    logic               neg_q, neg_d;
`endif

    logic               in_signed, in_neg_a, in_neg_b;
    logic [WIDTH-1:0]   in_mag_a, in_mag_b;
    logic [WIDTH:0]     shifted, trial;
    logic               div_zero;
    logic [WIDTH-1:0]   quo_res, rem_mag, rem_res;

    always_comb begin
        in_signed = ~DivOp[0];
        in_neg_a  = in_signed & SrcA[WIDTH-1];
        in_neg_b  = in_signed & SrcB[WIDTH-1];
        in_mag_a  = in_neg_a ? -SrcA : SrcA;
        in_mag_b  = in_neg_b ? -SrcB : SrcB;

        shifted   = {rem_q, quo_q[WIDTH-1]};
        trial     = shifted - {1'b0, div_q};

        // On divide-by-zero the FSM skips RUN, so quo_q still holds |SrcA|;
        // re-applying the dividend sign recovers the original SrcA.
        div_zero  = (div_q == '0);
        quo_res   = div_zero ? '1 : ((sign_a_q ^ sign_b_q) ? -quo_q : quo_q);
        rem_mag   = div_zero ? quo_q : rem_q;
        rem_res   = sign_a_q ? -rem_mag : rem_mag;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        dbz_d    = dbz_q;
`ifdef DIV_FLAGS_EN
        zero_d   = zero_q;
        neg_d    = neg_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    op_d     = DivOp;
                    sign_a_d = in_neg_a;
                    sign_b_d = in_neg_b;
                    quo_d    = in_mag_a;
                    div_d    = in_mag_b;
                    rem_d    = '0;
                    cnt_d    = '0;
                    state_d  = (SrcB == '0) ? StFix : StRun;
                end
            end
            StRun: begin
                // trial[WIDTH] is the borrow: set means the divisor did not fit.
                rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                result_d = op_q[1] ? rem_res : quo_res;
                dbz_d    = div_zero;
`ifdef DIV_FLAGS_EN
                zero_d   = (result_d == '0);
                neg_d    = result_d[WIDTH-1];
`endif
                state_d  = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
`ifdef DIV_FLAGS_EN
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
`ifdef DIV_FLAGS_EN
            zero_q   <= zero_d;
            neg_q    <= neg_d;
`endif
        end
    end

    assign Busy      = (state_q == StRun) || (state_q == StFix);
    assign Done      = (state_q == StDone);
    assign Result    = result_q;
    assign DivByZero = dbz_q;
`ifdef DIV_FLAGS_EN
    assign Zero      = zero_q;
    assign Negative  = neg_q;
`endif

endmodule

// File: tb/tb_iter_divider.sv
// Directed self-checking bench for iter_divider (WIDTH = 32).
// Flag checks are compiled in when DIV_FLAGS_EN is defined.
module tb_iter_divider;

    localparam logic [1:0] OpDiv  = 2'b00;
    localparam logic [1:0] OpDivu = 2'b01;
    localparam logic [1:0] OpRem  = 2'b10;
    localparam logic [1:0] OpRemu = 2'b11;

    logic        clk;
    logic        reset_n;
    logic        Start;
    logic [1:0]  DivOp;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;
    logic        DivByZero;
`ifdef DIV_FLAGS_EN
    logic        Zero;
    logic        Negative;
`endif

    int tests;
    int fails;

    iter_divider #(
        .WIDTH(32),
        .CNT_W(6)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .Start    (Start),
        .DivOp    (DivOp),
        .SrcA     (SrcA),
        .SrcB     (SrcB),
        .Busy     (Busy),
        .Done     (Done),
        .Result   (Result),
        .DivByZero(DivByZero)
`ifdef DIV_FLAGS_EN
        ,
        .Zero     (Zero),
        .Negative (Negative)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch one operation and wait (bounded) for Done; checks latency,
    // busy duration, result and divide-by-zero flag.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic exp_dbz, input int exp_lat);
        int lat;
        int busy_n;
        @(posedge clk);
        #1;
        Start = 1'b1;
        DivOp = op;
        SrcA  = a;
        SrcB  = b;
        @(posedge clk);
        #1;
        Start = 1'b0;
        DivOp = ~op;
        SrcA  = $urandom;
        SrcB  = $urandom;
        lat    = 0;
        busy_n = 0;
        for (int i = 1; i <= 60; i++) begin
            if (i > 1) begin
                @(posedge clk);
                #1;
            end
            if (Busy) busy_n++;
            if (Done) begin
                lat = i;
                break;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " busy"}, 32'(busy_n), 32'(exp_lat - 1));
        check({tag, " result"}, Result, exp_res);
        check({tag, " dbz"}, {31'b0, DivByZero}, {31'b0, exp_dbz});
        @(posedge clk);
        #1;
        check({tag, " done pulse"}, {31'b0, Done}, 32'd0);
        check({tag, " held"}, Result, exp_res);
    endtask

    initial begin
        bit saw_done;
        tests   = 0;
        fails   = 0;
        reset_n = 1'b0;
        Start   = 1'b0;
        DivOp   = 2'b00;
        SrcA    = '0;
        SrcB    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'b0, Busy}, 32'd0);
        check("reset done", {31'b0, Done}, 32'd0);
        check("reset result", Result, 32'd0);
        check("reset dbz", {31'b0, DivByZero}, 32'd0);
        reset_n = 1'b1;

        run_op("divu 100/7", OpDivu, 32'd100, 32'd7, 32'd14, 1'b0, 34);
        run_op("remu 100/7", OpRemu, 32'd100, 32'd7, 32'd2, 1'b0, 34);
        run_op("div -7/2", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 34);
        run_op("rem -7/2", OpRem, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 34);
        run_op("div ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 34);
        run_op("rem ovf", OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 34);
        run_op("divu /0", OpDivu, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1'b1, 2);
        run_op("rem /0", OpRem, 32'h1234, 32'd0, 32'h1234, 1'b1, 2);
        run_op("rem -5/0", OpRem, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b1, 2);
        run_op("div 7/-2", OpDiv, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 34);
        run_op("divu big", OpDivu, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 1'b0, 34);

        // Abort: re-pulsed Start is ignored, reset mid-operation kills Done.
        @(posedge clk);
        #1;
        Start = 1'b1;
        DivOp = OpDivu;
        SrcA  = 32'd1000;
        SrcB  = 32'd10;
        @(posedge clk);
        #1;
        Start    = 1'b0;
        saw_done = 1'b0;
        for (int i = 1; i < 20; i++) begin
            if (i > 1) begin
                @(posedge clk);
                #1;
            end
            if (Done) saw_done = 1'b1;
            if (i == 5) begin
                Start = 1'b1;
                SrcA  = 32'd77;
                SrcB  = 32'd0;
            end else begin
                Start = 1'b0;
            end
        end
        check("abort busy before reset", {31'b0, Busy}, 32'd1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("abort no done", {31'b0, saw_done}, 32'd0);
        check("abort busy", {31'b0, Busy}, 32'd0);
        check("abort done", {31'b0, Done}, 32'd0);
        check("abort result", Result, 32'd0);
        check("abort dbz", {31'b0, DivByZero}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n  = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (Done) saw_done = 1'b1;
        end
        check("post-reset idle", {31'b0, saw_done}, 32'd0);
        run_op("divu 1000/10", OpDivu, 32'd1000, 32'd10, 32'd100, 1'b0, 34);

`ifdef DIV_FLAGS_EN
        run_op("remu 9/3", OpRemu, 32'd9, 32'd3, 32'd0, 1'b0, 34);
        check("remu 9/3 zero", {31'b0, Zero}, 32'd1);
        check("remu 9/3 neg", {31'b0, Negative}, 32'd0);
        run_op("div -8/2", OpDiv, 32'hFFFF_FFF8, 32'd2, 32'hFFFF_FFFC, 1'b0, 34);
        check("div -8/2 zero", {31'b0, Zero}, 32'd0);
        check("div -8/2 neg", {31'b0, Negative}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
